// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one byte-wide UART transmitter between NUM_REQ producers. The grant
//   is round-robin and is held for a whole packet (through the byte flagged
//   req_last). The output byte is registered so that serializer timing stays
//   isolated from requester timing.
//
// Parameters
//   NUM_REQ       number of requesters (2..8)
//   IDLE_TIMEOUT  cycles the owner may hold req_valid low mid-packet before the
//                 packet is forced closed; 0 disables the timeout
//
// Ports
//   clk        system clock, all logic on posedge
//   reset      synchronous, active-high reset
//   req_valid  per-requester byte valid
//   req_data   per-requester byte, requester i on bits [8i+7:8i]
//   req_last   byte is the last of its packet
//   req_ready  byte accepted when req_valid[i] && req_ready[i]
//   tx_valid   registered byte valid to serializer
//   tx_data    registered byte to serializer
//   tx_ready   serializer accepts the byte this cycle
//   grant      one-hot current owner, zero when idle
//   busy       arbiter is not idle
//
// Build option
//   UART_ARB_FIXED_PRIO_EN  requester 0 always wins arbitration when it is
//                           requesting; requesters 1..NUM_REQ-1 rotate among
//                           themselves.
//
// state  | meaning
// IDLE   | no owner; arbitrate among valid requesters
// LOCKED | owner holds the transmitter, bytes accepted into the output reg
// DRAIN  | packet ended; wait for the last byte to leave, then release

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_LIMIT = CW'(IDLE_TIMEOUT);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE  = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [NUM_REQ-1:0]   grant_nxt;
    logic [IW-1:0]        owner, owner_nxt;
    logic [IW-1:0]        last_owner, last_owner_nxt;
    logic [CW-1:0]        tmo_cnt, tmo_nxt;
    logic                 tx_valid_nxt;
    logic [7:0]           tx_data_nxt;

    logic                 win_found;
    logic [IW-1:0]        win_idx;
    logic                 accept;
    logic                 own_valid;
    logic                 own_last;
    logic [7:0]           own_data;

    // Search upward from the previous owner so the last winner goes to the back.
    always_comb begin
        logic [IW-1:0] cand;
        logic          cand_ok;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        cand_ok   = 1'b0;
`ifdef UART_ARB_FIXED_PRIO_EN
        if (req_valid[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
        end
`endif
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand    = IW'((int'(last_owner) + k) % NUM_REQ);
            cand_ok = req_valid[cand];
`ifdef UART_ARB_FIXED_PRIO_EN
            if (cand == '0) cand_ok = 1'b0;
`endif
            if (!win_found && cand_ok) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Ready depends only on registers and tx_ready, never on req_valid.
    always_comb begin
        req_ready = '0;
        if (state == ST_LOCKED && (!tx_valid || tx_ready))
            req_ready = grant;
    end

    assign own_valid = req_valid[owner];
    assign own_last  = req_last[owner];
    assign own_data  = req_data[8*int'(owner) +: 8];
    assign accept    = |(req_valid & req_ready);
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        tmo_nxt        = tmo_cnt;
        tx_valid_nxt   = tx_valid;
        tx_data_nxt    = tx_data;

        if (accept) begin
            tx_valid_nxt = 1'b1;
            tx_data_nxt  = own_data;
        end else if (tx_valid && tx_ready) begin
            tx_valid_nxt = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                tmo_nxt = '0;
                if (win_found) begin
                    state_nxt = ST_LOCKED;
                    grant_nxt = ONE << win_idx;
                    owner_nxt = win_idx;
                end
            end
            ST_LOCKED: begin
                if (accept) begin
                    tmo_nxt = '0;
                    if (own_last)
                        state_nxt = ST_DRAIN;
                end else if (!own_valid) begin
                    if (tmo_cnt != {CW{1'b1}})
                        tmo_nxt = tmo_cnt + CW'(1);
                    // A stalled owner is treated as having ended its packet.
                    if (IDLE_TIMEOUT != 0 && tmo_nxt >= TMO_LIMIT)
                        state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!tx_valid || tx_ready) begin
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
                    if (owner != '0)
                        last_owner_nxt = owner;
`else
                    last_owner_nxt = owner;
`endif
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= '0;
            owner      <= '0;
            last_owner <= LAST_IDX;
            tmo_cnt    <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            tmo_cnt    <= tmo_nxt;
            tx_valid   <= tx_valid_nxt;
            tx_data    <= tx_data_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (NUM_REQ=4, IDLE_TIMEOUT=8).
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int TMO = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*N-1:0] req_data;
    logic           tx_valid, tx_ready, busy;
    logic [7:0]     tx_data;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .IDLE_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .busy      (busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Packet sources used by run_packets: per requester, flattened bytes and last flags.
    logic [7:0] pb[N][$];
    logic       pl[N][$];

    // Packet-level arbitration rule: next requester with packets left, searching
    // upward from the previous owner (requester 0 first in the fixed-priority build).
    function automatic int pick(input int last_o, input logic [N-1:0] avail);
        int c;
`ifdef UART_ARB_FIXED_PRIO_EN
        if (avail[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            c = (last_o + k) % N;
`ifdef UART_ARB_FIXED_PRIO_EN
            if (c == 0) continue;
`endif
            if (avail[c]) return c;
        end
        return -1;
    endfunction

    task automatic run_packets(input int txr_pct, input int gap_max, input string tag);
        logic [7:0]   exp_q[$];
        logic [N-1:0] avail;
        logic [N-1:0] hs;
        int           mpos[N];
        int           pos[N];
        int           gap[N];
        int           last_o, w, got, cyc;
        logic         prev_stall;
        logic [7:0]   prev_data;

        // Expected output byte stream, whole packets in arbitration order.
        for (int i = 0; i < N; i++) mpos[i] = 0;
        last_o = N - 1;
        forever begin
            for (int i = 0; i < N; i++) avail[i] = (mpos[i] < pb[i].size());
            w = pick(last_o, avail);
            if (w < 0) break;
            do begin
                exp_q.push_back(pb[w][mpos[w]]);
                mpos[w]++;
            end while (!pl[w][mpos[w]-1]);
`ifdef UART_ARB_FIXED_PRIO_EN
            if (w != 0) last_o = w;
`else
            last_o = w;
`endif
        end

        do_reset();
        for (int i = 0; i < N; i++) begin
            pos[i] = 0;
            gap[i] = 0;
        end
        got        = 0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        for (cyc = 0; cyc < 3000 && got < exp_q.size(); cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (pos[i] < pb[i].size() && gap[i] == 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = pb[i][pos[i]];
                    req_last[i]        = pl[i][pos[i]];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                    if (gap[i] > 0) gap[i]--;
                end
            end
            tx_ready = ($urandom_range(0, 99) < txr_pct);
            @(negedge clk);
            hs = req_valid & req_ready;
            chk({tag, " grant_onehot"}, 32'($onehot0(grant)), 32'd1);
            chk({tag, " ready_non_owner"}, 32'(req_ready & ~grant), 32'd0);
            if (prev_stall) begin
                chk({tag, " stall_valid"}, 32'(tx_valid), 32'd1);
                chk({tag, " stall_data"}, 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                chk({tag, " byte"}, 32'(tx_data), 32'(exp_q[got]));
                got++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            next_cycle();
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    if (!pl[i][pos[i]]) gap[i] = $urandom_range(0, gap_max);
                    pos[i]++;
                end
            end
        end
        chk({tag, " byte_count"}, 32'(got), 32'(exp_q.size()));
        req_valid = '0;
        req_last  = '0;
        tx_ready  = 1'b1;
        repeat (4) next_cycle();
    endtask

    typedef struct {
        logic [3:0] rv;
        logic [3:0] rl;
        logic       txr;
        logic [3:0] e_grant;
        logic       e_busy;
        logic       e_txv;
        logic [7:0] e_txd;
        logic [3:0] e_rr;
    } vec_t;

    vec_t vt[12];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Cycle-by-cycle table from reset; req_data fixed: r0=41, r1=21, r2=32.
        //            rv       rl       txr   grant    busy  txv   txd    rr
        vt[0]  = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
        vt[1]  = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0, 8'h00, 4'b0001};
        vt[2]  = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h41, 4'b0000};
        vt[3]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h41, 4'b0000};
        vt[4]  = '{4'b0110, 4'b0110, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h41, 4'b0000};
        vt[5]  = '{4'b0110, 4'b0110, 1'b0, 4'b0010, 1'b1, 1'b0, 8'h41, 4'b0010};
        vt[6]  = '{4'b0100, 4'b0100, 1'b0, 4'b0010, 1'b1, 1'b1, 8'h21, 4'b0000};
        vt[7]  = '{4'b0100, 4'b0100, 1'b1, 4'b0010, 1'b1, 1'b1, 8'h21, 4'b0000};
        vt[8]  = '{4'b0100, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h21, 4'b0000};
        vt[9]  = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0, 8'h21, 4'b0100};
        vt[10] = '{4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b1, 8'h32, 4'b0000};
        vt[11] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h32, 4'b0000};

        do_reset();
        @(negedge clk);
        chk("reset grant", 32'(grant), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset tx_valid", 32'(tx_valid), 32'd0);
        chk("reset tx_data", 32'(tx_data), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        next_cycle();

        req_data = 32'h0032_2141;
        for (int k = 0; k < 12; k++) begin
            req_valid = vt[k].rv;
            req_last  = vt[k].rl;
            tx_ready  = vt[k].txr;
            @(negedge clk);
            chk($sformatf("vec%0d grant", k), 32'(grant), 32'(vt[k].e_grant));
            chk($sformatf("vec%0d busy", k), 32'(busy), 32'(vt[k].e_busy));
            chk($sformatf("vec%0d tx_valid", k), 32'(tx_valid), 32'(vt[k].e_txv));
            chk($sformatf("vec%0d tx_data", k), 32'(tx_data), 32'(vt[k].e_txd));
            chk($sformatf("vec%0d req_ready", k), 32'(req_ready), 32'(vt[k].e_rr));
            next_cycle();
        end

        // Serializer stalled for 20 cycles with a byte in the output register.
        do_reset();
        req_valid = 4'b0001;
        req_data  = 32'h0000_0055;
        req_last  = 4'b0000;
        tx_ready  = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("stall first_accept", 32'(req_ready), 32'h1);
        next_cycle();
        req_data = 32'h0000_0056;
        req_last = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("stall hold_valid", 32'(tx_valid), 32'd1);
            chk("stall hold_data", 32'(tx_data), 32'h55);
            chk("stall ready_low", 32'(req_ready), 32'd0);
            next_cycle();
        end
        tx_ready = 1'b1;
        @(negedge clk);
        chk("stall release_ready", 32'(req_ready), 32'h1);
        next_cycle();
        req_valid = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        @(negedge clk);
        chk("stall next_valid", 32'(tx_valid), 32'd1);
        chk("stall next_data", 32'(tx_data), 32'h56);
        tx_ready = 1'b1;
        repeat (3) next_cycle();

        // Owner goes quiet mid-packet; requester 1 waits.
        do_reset();
        req_valid = 4'b0011;
        req_data  = 32'h0000_B1A0;
        req_last  = 4'b0010;
        tx_ready  = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("tmo grant0", 32'(grant), 32'h1);
        chk("tmo accept", 32'(req_ready), 32'h1);
        next_cycle();
        req_valid = 4'b0010;
        for (int c = 2; c <= 9; c++) begin
            @(negedge clk);
            chk($sformatf("tmo locked c%0d", c), 32'(req_ready), 32'h1);
            next_cycle();
        end
        @(negedge clk);
        chk("tmo drain_grant", 32'(grant), 32'h1);
        chk("tmo drain_busy", 32'(busy), 32'd1);
        chk("tmo drain_ready", 32'(req_ready), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("tmo released_grant", 32'(grant), 32'd0);
        chk("tmo released_busy", 32'(busy), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("tmo next_owner", 32'(grant), 32'h2);
        next_cycle();
        req_valid = '0;
        req_last  = '0;
        repeat (4) next_cycle();

        // Reset while a byte is waiting in the output register.
        do_reset();
        req_valid = 4'b0001;
        req_data  = 32'h0000_0077;
        req_last  = 4'b0000;
        tx_ready  = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_mid pre_valid", 32'(tx_valid), 32'd1);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("rst_mid tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_mid grant", 32'(grant), 32'd0);
        chk("rst_mid busy", 32'(busy), 32'd0);
        next_cycle();
        reset     = 1'b0;
        req_valid = 4'b0011;
        next_cycle();
        @(negedge clk);
        chk("rst_mid first_winner", 32'(grant), 32'h1);
        next_cycle();

        // Four simultaneous two-byte packets, serializer always ready.
        for (int i = 0; i < N; i++) begin
            pb[i].delete();
            pl[i].delete();
            pb[i].push_back(8'(8'h30 + i));
            pl[i].push_back(1'b0);
            pb[i].push_back(8'(8'h40 + i));
            pl[i].push_back(1'b1);
        end
        run_packets(100, 0, "four");

        // Requesters 0 and 2 with back-to-back single-byte packets.
        for (int i = 0; i < N; i++) begin
            pb[i].delete();
            pl[i].delete();
        end
        for (int p = 0; p < 3; p++) begin
            pb[0].push_back(8'(8'hA0 + p));
            pl[0].push_back(1'b1);
            pb[2].push_back(8'(8'hC0 + p));
            pl[2].push_back(1'b1);
        end
        run_packets(100, 0, "prio");

        // Random packets, random serializer back-pressure, short mid-packet gaps.
        for (int r = 0; r < 4; r++) begin
            int npk, len;
            for (int i = 0; i < N; i++) begin
                pb[i].delete();
                pl[i].delete();
                npk = (i == 0) ? $urandom_range(1, 3) : $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) begin
                        pb[i].push_back(8'($urandom_range(0, 255)));
                        pl[i].push_back(b == len - 1);
                    end
                end
            end
            run_packets($urandom_range(30, 100), 2, $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
